// File: rtl/gate_selftest_seq_if.sv
// Signal bundle between the gate self-test sequencer (master) and the gate set
// plus its run controller (slave).
interface gate_selftest_seq_if #(
    parameter int ERR_CNT_W = 4
);
    // Run handshake: start is a level request honoured only while the sequencer
    // is idle; busy covers the whole run, and done pulses for exactly one cycle
    // when results (pass, err_count, fail_mask) are final. No back-pressure exists.
    logic                 start;
    logic                 or_i;
    logic                 not_i;
    logic                 nand_i;
    logic                 nor_i;
    logic                 xnor_i;
    logic                 xor_i;
    logic                 a_o;
    logic                 b_o;
    logic                 busy;
    logic                 done;
    logic                 pass;
    logic [ERR_CNT_W-1:0] err_count;
    logic [5:0]           fail_mask;
    logic [1:0]           vec_idx;
    logic [2:0]           fsm_state;

    modport master (
        input  start, or_i, not_i, nand_i, nor_i, xnor_i, xor_i,
        output a_o, b_o, busy, done, pass, err_count, fail_mask, vec_idx, fsm_state
    );

    modport slave (
        output start, or_i, not_i, nand_i, nor_i, xnor_i, xor_i,
        input  a_o, b_o, busy, done, pass, err_count, fail_mask, vec_idx, fsm_state
    );
endinterface

// File: rtl/gate_selftest_seq.sv
// Self-test sequencer: walks a/b through 00,10,11,01, samples six gate outputs
// after a settle delay and accumulates mismatch results.
module gate_selftest_seq #(
    parameter int SETTLE_CYCLES = 2,
    parameter int ERR_CNT_W     = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    gate_selftest_seq_if.master  bus
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DRIVE  = 3'd1,
        SETTLE = 3'd2,
        CHECK  = 3'd3,
        DONE   = 3'd4
    } state_t;

    localparam int          SETTLE_LAST_I = (SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0;
    localparam logic [7:0]  SETTLE_LAST   = 8'(SETTLE_LAST_I);

    state_t               state_q, state_d;
    logic [7:0]           cnt_q, cnt_d;
    logic                 a_q, a_d, b_q, b_d;
    logic [1:0]           vec_q, vec_d;
    logic [ERR_CNT_W-1:0] err_q, err_d;
    logic [5:0]           mask_q, mask_d;
    logic                 pass_q, pass_d;
    logic [5:0]           gold;
    logic [5:0]           mm;

    // Returns {a,b} for a vector index.
    function automatic logic [1:0] vec_ab(input logic [1:0] idx);
        case (idx)
            2'd0:    vec_ab = 2'b00;
            2'd1:    vec_ab = 2'b10;
            2'd2:    vec_ab = 2'b11;
            default: vec_ab = 2'b01;
        endcase
    endfunction

    always_comb begin
        gold = {a_q | b_q, ~a_q, ~(a_q & b_q), ~(a_q | b_q), ~(a_q ^ b_q), a_q ^ b_q};
        // Case inequality so an undriven or unknown gate output flags a mismatch.
        mm[5] = (bus.or_i   !== gold[5]);
        mm[4] = (bus.not_i  !== gold[4]);
        mm[3] = (bus.nand_i !== gold[3]);
        mm[2] = (bus.nor_i  !== gold[2]);
        mm[1] = (bus.xnor_i !== gold[1]);
        mm[0] = (bus.xor_i  !== gold[0]);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        vec_d   = vec_q;
        err_d   = err_q;
        mask_d  = mask_q;
        pass_d  = pass_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d    = DRIVE;
                    vec_d      = 2'd0;
                    err_d      = '0;
                    mask_d     = '0;
                    pass_d     = 1'b0;
                    {a_d, b_d} = vec_ab(2'd0);
                end
            end
            DRIVE: begin
                cnt_d = '0;
                if (SETTLE_CYCLES == 0) state_d = CHECK;
                else                    state_d = SETTLE;
            end
            SETTLE: begin
                if (cnt_q == SETTLE_LAST) state_d = CHECK;
                else                      cnt_d   = cnt_q + 8'd1;
            end
            CHECK: begin
                mask_d = mask_q | mm;
                if ((|mm) && (err_q != '1)) err_d = err_q + 1'b1;
                if (vec_q == 2'd3) begin
                    state_d = DONE;
                    pass_d  = (err_q == '0) && !(|mm);
                    a_d     = 1'b0;
                    b_d     = 1'b0;
                end else begin
                    state_d    = DRIVE;
                    vec_d      = vec_q + 2'd1;
                    {a_d, b_d} = vec_ab(vec_q + 2'd1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                a_d     = 1'b0;
                b_d     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            vec_q   <= '0;
            err_q   <= '0;
            mask_q  <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            vec_q   <= vec_d;
            err_q   <= err_d;
            mask_q  <= mask_d;
            pass_q  <= pass_d;
        end
    end

    assign bus.a_o       = a_q;
    assign bus.b_o       = b_q;
    assign bus.busy      = (state_q == DRIVE) || (state_q == SETTLE) || (state_q == CHECK);
    assign bus.done      = (state_q == DONE);
    assign bus.pass      = pass_q;
    assign bus.err_count = err_q;
    assign bus.fail_mask = mask_q;
    assign bus.vec_idx   = vec_q;
    assign bus.fsm_state = state_q;
endmodule

// File: tb/tb_gate_selftest_seq.sv
// Bench for gate_selftest_seq: behavioural gate models with injectable faults,
// a vector-order reference model and per-scenario checking tasks.
module tb_gate_selftest_seq;
    logic clk;
    logic rst_n;
    logic start_r;
    logic sel;
    int   fault_mode;
    logic [5:0] flip_tab [4];
    int   n_total;
    int   n_pass;

    gate_selftest_seq_if #(.ERR_CNT_W(4)) if0 ();
    gate_selftest_seq_if #(.ERR_CNT_W(4)) if1 ();

    gate_selftest_seq #(.SETTLE_CYCLES(2), .ERR_CNT_W(4)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.master));
    gate_selftest_seq #(.SETTLE_CYCLES(0), .ERR_CNT_W(4)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.master));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [5:0] golden(input logic a, input logic b);
        golden = {a | b, ~a, ~(a & b), ~(a | b), ~(a ^ b), a ^ b};
    endfunction

    function automatic logic [5:0] gate_model(input logic a, input logic b, input int mode,
                                              input logic [5:0] flip);
        logic [5:0] g;
        g = golden(a, b);
        case (mode)
            1:       gate_model = {g[5:1], 1'b0};
            2:       gate_model = {g[5], ~b, g[3:0]};
            default: gate_model = g ^ flip;
        endcase
    endfunction

    always_comb begin
        {if0.or_i, if0.not_i, if0.nand_i, if0.nor_i, if0.xnor_i, if0.xor_i} =
            gate_model(if0.a_o, if0.b_o, fault_mode, flip_tab[{if0.a_o, if0.b_o}]);
        {if1.or_i, if1.not_i, if1.nand_i, if1.nor_i, if1.xnor_i, if1.xor_i} = golden(if1.a_o, if1.b_o);
        if0.start = start_r & ~sel;
        if1.start = start_r & sel;
    end

    logic       obs_a, obs_b, obs_busy, obs_done, obs_pass;
    logic [3:0] obs_err;
    logic [5:0] obs_mask;
    logic [1:0] obs_vec;
    always_comb begin
        obs_a    = sel ? if1.a_o       : if0.a_o;
        obs_b    = sel ? if1.b_o       : if0.b_o;
        obs_busy = sel ? if1.busy      : if0.busy;
        obs_done = sel ? if1.done      : if0.done;
        obs_pass = sel ? if1.pass      : if0.pass;
        obs_err  = sel ? if1.err_count : if0.err_count;
        obs_mask = sel ? if1.fail_mask : if0.fail_mask;
        obs_vec  = sel ? if1.vec_idx   : if0.vec_idx;
    end

    // Reference: walk the documented vector order, each flipped gate is a mismatch.
    task automatic model_run(output logic [5:0] mask, output logic [3:0] err, output logic pass);
        logic [1:0] order [4];
        order = '{2'b00, 2'b10, 2'b11, 2'b01};
        mask = '0;
        err  = '0;
        for (int i = 0; i < 4; i++) begin
            mask = mask | flip_tab[order[i]];
            if (flip_tab[order[i]] != 6'd0 && err != 4'hf) err = err + 4'd1;
        end
        pass = (err == 4'd0);
    endtask

    // Runs one sequence from IDLE and checks every cycle up to and including DONE.
    task automatic run_watch(input int settle, input logic [5:0] exp_mask, input logic [3:0] exp_err,
                             input logic exp_pass, input bit hold, input string name);
        logic [1:0] order [4];
        logic [5:0] exp_tr, got_tr;
        int span, v;
        order = '{2'b00, 2'b10, 2'b11, 2'b01};
        span  = 4 * (settle + 2);
        start_r = 1'b1;
        @(posedge clk);
        for (int k = 0; k <= span; k++) begin
            @(negedge clk);
            if (k == 0 && !hold) start_r = 1'b0;
            got_tr = {obs_a, obs_b, obs_busy, obs_done, obs_vec};
            if (k < span) begin
                v = k / (settle + 2);
                exp_tr = {order[v], 1'b1, 1'b0, 2'(v)};
            end else begin
                exp_tr = {2'b00, 1'b0, 1'b1, 2'd3};
            end
            n_total++;
            if (got_tr !== exp_tr) $display("FAIL %s trace k=%0d: got %b expected %b", name, k, got_tr, exp_tr);
            else n_pass++;
            if (k == 0) begin
                n_total++;
                if ({obs_err, obs_mask, obs_pass} !== 11'd0)
                    $display("FAIL %s accept_clear: got err=%0d mask=%b pass=%b expected all 0", name, obs_err, obs_mask, obs_pass);
                else n_pass++;
            end
        end
        n_total++;
        if ({obs_pass, obs_err, obs_mask} !== {exp_pass, exp_err, exp_mask})
            $display("FAIL %s result: got pass=%b err=%0d mask=%b expected pass=%b err=%0d mask=%b",
                     name, obs_pass, obs_err, obs_mask, exp_pass, exp_err, exp_mask);
        else n_pass++;
        if (!hold) begin
            @(negedge clk);
            n_total++;
            if ({obs_busy, obs_done, obs_pass} !== {2'b00, exp_pass})
                $display("FAIL %s after_done: got busy=%b done=%b pass=%b expected 0 0 %b",
                         name, obs_busy, obs_done, obs_pass, exp_pass);
            else n_pass++;
        end
    endtask

    task automatic check_all_zero(input string name);
        logic [17:0] z0, z1;
        z0 = {if0.a_o, if0.b_o, if0.busy, if0.done, if0.pass, if0.err_count, if0.fail_mask, if0.vec_idx};
        z1 = {if1.a_o, if1.b_o, if1.busy, if1.done, if1.pass, if1.err_count, if1.fail_mask, if1.vec_idx};
        n_total++;
        if (z0 !== 18'd0 || z1 !== 18'd0) $display("FAIL %s: got %b / %b expected all zero", name, z0, z1);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_all_zero("reset_outputs");
        rst_n = 1'b1;
        @(negedge clk);
        check_all_zero("idle_after_reset");
    endtask

    task automatic test_correct();
        fault_mode = 0;
        for (int i = 0; i < 4; i++) flip_tab[i] = 6'd0;
        run_watch(2, 6'b000000, 4'd0, 1'b1, 1'b0, "correct");
    endtask

    task automatic test_xor_stuck();
        fault_mode = 1;
        run_watch(2, 6'b000001, 4'd2, 1'b0, 1'b0, "xor_stuck0");
    endtask

    task automatic test_not_fault();
        fault_mode = 2;
        run_watch(2, 6'b010000, 4'd2, 1'b0, 1'b0, "not_uses_b");
    endtask

    task automatic test_back_to_back();
        fault_mode = 1;
        run_watch(2, 6'b000001, 4'd2, 1'b0, 1'b1, "b2b_first");
        fault_mode = 0;
        @(negedge clk);
        n_total++;
        if ({obs_busy, obs_done, obs_err, obs_mask} !== {2'b00, 4'd2, 6'b000001})
            $display("FAIL b2b_idle_gap: got busy=%b done=%b err=%0d mask=%b expected 0 0 2 000001",
                     obs_busy, obs_done, obs_err, obs_mask);
        else n_pass++;
        run_watch(2, 6'b000000, 4'd0, 1'b1, 1'b0, "b2b_second");
    endtask

    task automatic test_random();
        logic [5:0] em;
        logic [3:0] ee;
        logic       ep;
        fault_mode = 0;
        for (int it = 0; it < 6; it++) begin
            for (int i = 0; i < 4; i++)
                flip_tab[i] = ($urandom_range(0, 2) == 0) ? 6'($urandom_range(1, 63)) : 6'd0;
            model_run(em, ee, ep);
            run_watch(2, em, ee, ep, 1'b0, $sformatf("random%0d", it));
        end
        for (int i = 0; i < 4; i++) flip_tab[i] = 6'd0;
    endtask

    task automatic test_reset_mid_run();
        fault_mode = 0;
        start_r = 1'b1;
        @(posedge clk);
        for (int k = 0; k <= 9; k++) begin
            @(negedge clk);
            if (k == 0) start_r = 1'b0;
        end
        n_total++;
        if ({obs_busy, obs_vec, obs_a, obs_b} !== {1'b1, 2'd2, 2'b11})
            $display("FAIL midrun_pre: got busy=%b vec=%0d ab=%b%b expected 1 2 11", obs_busy, obs_vec, obs_a, obs_b);
        else n_pass++;
        rst_n = 1'b0;
        #1;
        check_all_zero("midrun_async_reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            n_total++;
            if ({obs_busy, obs_done, obs_pass} !== 3'b000)
                $display("FAIL midrun_idle k=%0d: got busy=%b done=%b pass=%b expected 0 0 0", k, obs_busy, obs_done, obs_pass);
            else n_pass++;
        end
    endtask

    task automatic test_settle0();
        sel = 1'b1;
        run_watch(0, 6'b000000, 4'd0, 1'b1, 1'b0, "settle0");
        sel = 1'b0;
    endtask

    initial begin
        n_total    = 0;
        n_pass     = 0;
        start_r    = 1'b0;
        sel        = 1'b0;
        fault_mode = 0;
        for (int i = 0; i < 4; i++) flip_tab[i] = 6'd0;
        test_reset();
        test_correct();
        test_xor_stuck();
        test_not_fault();
        test_back_to_back();
        test_random();
        test_reset_mid_run();
        test_settle0();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/gate_selftest_seq.md
Name: gate_selftest_seq

Overview:
- Synchronous self-test sequencer for the two-input gate set (OR, NOT, NAND, NOR, XNOR, XOR).
- Upstream, it drives the shared a/b stimulus pair through all four input combinations.
- Downstream, it samples the six gate outputs after a settle delay, compares them with golden values, and reports a pass/fail summary.
- It replaces hand-written initial-block stimulus. The gate set can then be checked in a clocked environment or on silicon.

Parameters:
- SETTLE_CYCLES, 2: idle cycles between driving a vector and sampling the gate outputs. Legal range 0..255.
- ERR_CNT_W, 4: width of err_count. Minimum legal value is 3.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  run request; sampled only in IDLE.
- or_i  input  1  OR gate output.
- not_i  input  1  NOT gate output (inverts a).
- nand_i  input  1  NAND gate output.
- nor_i  input  1  NOR gate output.
- xnor_i  input  1  XNOR gate output.
- xor_i  input  1  XOR gate output.
- a_o  output  1  stimulus a, registered.
- b_o  output  1  stimulus b, registered.
- busy  output  1  high from DRIVE of vector 0 through the last CHECK.
- done  output  1  one-cycle pulse when a run completes.
- pass  output  1  high when the last run had zero mismatches; held until next accepted start.
- err_count  output  ERR_CNT_W  count of vectors with at least one mismatching output.
- fail_mask  output  6  sticky per-gate mismatch flags. Bit order: [5] OR, [4] NOT, [3] NAND, [2] NOR, [1] XNOR, [0] XOR.
- vec_idx  output  2  index of the vector currently applied.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - rst_n low immediately forces state IDLE.
  - While rst_n is low, all outputs are 0: a_o, b_o, busy, done, pass, err_count, fail_mask and vec_idx.
- Vector order (vec_idx 0..3, as a,b): 00, 10, 11, 01.
- Golden values per vector: OR=a|b, NOT=~a, NAND=~(a&b), NOR=~(a|b), XNOR=~(a^b), XOR=a^b.
- FSM states: IDLE, DRIVE, SETTLE, CHECK, DONE.
- IDLE:
  - a_o=b_o=0 and busy=0.
  - start=1 at an edge moves to DRIVE, clears err_count and fail_mask, sets vec_idx=0 and pass=0.
- DRIVE: one cycle. a_o/b_o take vector[vec_idx], busy=1. Moves to SETTLE, or directly to CHECK if SETTLE_CYCLES=0.
- SETTLE: lasts exactly SETTLE_CYCLES cycles, counted by an internal counter; a_o/b_o held. Then moves to CHECK.
- CHECK: one cycle.
  - Each gate input is compared with its golden value. Any X or Z input counts as a mismatch (case-equality compare).
  - fail_mask |= mismatch bits.
  - err_count increments by 1 if any bit mismatches. It saturates at all-ones.
  - If vec_idx==3, move to DONE. Otherwise vec_idx increments and the FSM moves to DRIVE.
- DONE: one cycle.
  - done=1 and busy=0.
  - pass = (err_count==0 and no mismatch in the final CHECK).
  - a_o=b_o=0, then move to IDLE.
- Latency:
  - done is high in the cycle beginning 4*(SETTLE_CYCLES+2) edges after the edge that samples start.
  - Each vector is held on a_o/b_o for SETTLE_CYCLES+2 cycles.
- start outside IDLE (including DONE) is ignored. start held high re-triggers on the first IDLE cycle after DONE.
- Gate inputs are sampled only in CHECK; their values in other states have no effect.
- Reset mid-run aborts with no done pulse; pass stays 0 until a later run completes.

Test Plan:
1. SETTLE_CYCLES=2, correct gate models, start pulse
   -> a_o/b_o = 00,10,11,01, each held 4 cycles;
   -> done at edge 16, pass=1, err_count=0, fail_mask=000000.
2. xor_i tied to 0
   -> mismatches at vectors 10 and 01;
   -> err_count=2, fail_mask=000001, pass=0.
3. not_i driven as ~b instead of ~a
   -> mismatches at vectors 10 and 01;
   -> err_count=2, fail_mask=010000, pass=0.
4. start held high continuously
   -> second run begins in the IDLE cycle after done;
   -> err_count/fail_mask from case 2 are cleared at that accept;
   -> no restart while busy.
5. rst_n pulsed low during SETTLE of vec_idx=2
   -> all outputs 0 immediately, no done pulse;
   -> after release stays in IDLE until start.
6. SETTLE_CYCLES=0 instance with correct gates
   -> each vector held 2 cycles, done at edge 8, pass=1.
